// File: rtl/i2s_pkg.sv
// Shared types and frame geometry for the I2S playback/capture path.
// Exports sample/slot types and the slot-to-bit mapping helper.
package i2s_pkg;

    localparam int SAMPLE_W      = 24;
    localparam int SLOTS_PER_CH  = 32;
    localparam int CLK_PER_BCK   = 4;
    localparam int CLK_PER_FRAME = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [4:0]          slot_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] pos;
    } bit_sel_t;

    // Slot 0 is the one-BCK I2S delay; slots 1..width carry MSB first.
    function automatic bit_sel_t bit_index(slot_t slot, int unsigned width);
        bit_sel_t r;
        r = '0;
        if (slot != '0 && 32'(slot) <= width) begin
            r.hit = 1'b1;
            r.pos = 5'(width - 32'(slot));
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair stream from the DSP datapath into the I2S transmitter.
// Ports: s_left/s_right (pair), s_valid (source), s_ready (sink).
interface i2s_tx_if #(
    parameter int DATA_W = i2s_pkg::SAMPLE_W
);

    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_left,
        output s_right,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_left,
        input  s_right,
        input  s_valid,
        output s_ready
    );

endinterface

// File: rtl/i2s_clkgen.sv
// Frame counter and registered BCK/LRCK, shared by both I2S directions.
// Ports: clk, reset in; bck, lrck, next slot/channel, load (cnt==255) out.
module i2s_clkgen
    import i2s_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    output logic  bck,
    output logic  lrck,
    output slot_t slot_nxt,
    output logic  chan_nxt,
    output logic  load
);

    localparam int CW = $clog2(CLK_PER_FRAME);
    localparam int BW = $clog2(CLK_PER_BCK);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt  = cnt + 1'b1;
    assign load     = &cnt;
    // Registered outputs are fed from cnt_nxt so they track cnt exactly.
    assign slot_nxt = cnt_nxt[CW-2:BW];
    assign chan_nxt = cnt_nxt[CW-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            bck  <= 1'b0;
            lrck <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            bck  <= cnt_nxt[BW-1];
            lrck <= cnt_nxt[CW-1];
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: depth-1 holding buffer, per-frame load, MSB-first dout.
// Ports: clk, reset, s (pair stream), scki/bck/lrck/dout, frame_start, underrun.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W
) (
    input  logic     clk,
    input  logic     reset,
    i2s_tx_if.slave  s,
    output logic     scki,
    output logic     bck,
    output logic     lrck,
    output logic     dout,
    output logic     frame_start,
    output logic     underrun
);

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] tx_l;
    logic [DATA_W-1:0] tx_r;
    logic              hold_valid;
    logic              ready;
    logic              accept;
    logic              load;
    logic              chan_nxt;
    slot_t             slot_nxt;
    bit_sel_t          sel;
    logic              dout_nxt;

    i2s_clkgen u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .bck      (bck),
        .lrck     (lrck),
        .slot_nxt (slot_nxt),
        .chan_nxt (chan_nxt),
        .load     (load)
    );

    assign scki      = clk;
    // The load edge frees the buffer, so a new pair may land in the same cycle.
    assign ready     = !hold_valid || load;
    assign s.s_ready = ready;
    assign accept    = s.s_valid && ready;

    // At the load edge the next slot is 0, so the stale tx is never shown.
    always_comb begin
        sel      = bit_index(slot_nxt, DATA_W);
        dout_nxt = 1'b0;
        if (sel.hit) begin
            dout_nxt = chan_nxt ? tx_r[sel.pos] : tx_l[sel.pos];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_l      <= '0;
            hold_r      <= '0;
            hold_valid  <= 1'b0;
            tx_l        <= '0;
            tx_r        <= '0;
            dout        <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            dout        <= dout_nxt;
            frame_start <= load;
            underrun    <= load && !hold_valid;
            if (load) begin
                tx_l       <= hold_valid ? hold_l : '0;
                tx_r       <= hold_valid ? hold_r : '0;
                hold_valid <= accept;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
            if (accept) begin
                hold_l <= s.s_left;
                hold_r <= s.s_right;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized self-checking bench for i2s_tx with a frame-level scoreboard.
// Monitor decodes dout per frame; tasks compare against expected frames.
module tb_i2s_tx;

    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         fs;
        logic         ur;
        logic         junk;
    } frm_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scki, bck, lrck, dout, frame_start, underrun;

    i2s_tx_if #(.DATA_W(W)) sif ();

    i2s_tx #(.DATA_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (sif.slave),
        .scki        (scki),
        .bck         (bck),
        .lrck        (lrck),
        .dout        (dout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int gi = 0;

    // Reference frame counter: cycles since reset release, mod 256.
    logic [7:0] mcnt;
    int         cyc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) mcnt <= 8'd0;
        else       mcnt <= mcnt + 8'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    frm_t  got_q[$];
    frm_t  exp_q[$];
    pair_t pend[$];
    logic  fbits [256];
    logic  cur_fs, cur_ur, cur_junk;
    logic  prev_bck, prev_lrck, prev_dout, b, acc;
    bit    have_prev = 0;
    bit    in_rst = 1;
    int    geo_err = 0;
    int    rdy_err = 0;
    int    bck_rise = 0;
    int    lrck_rise = 0;
    frm_t  f, e;
    pair_t p;

    always @(negedge clk) begin
        if (reset) begin
            in_rst = 1;
            have_prev = 0;
            got_q.delete();
            exp_q.delete();
            pend.delete();
        end else begin
            if (in_rst) begin
                in_rst = 0;
                exp_q.push_back('0);
            end
            if (bck !== mcnt[1] || lrck !== mcnt[7]) geo_err++;
            if (have_prev) begin
                if (dout !== prev_dout && mcnt[1:0] != 2'd0) geo_err++;
                if (bck && !prev_bck) bck_rise++;
                if (lrck && !prev_lrck) lrck_rise++;
            end
            prev_bck = bck;
            prev_lrck = lrck;
            prev_dout = dout;
            have_prev = 1;
            if (sif.s_ready !== (pend.size() == 0 || mcnt == 8'hFF))
                rdy_err++;
            acc = sif.s_valid && sif.s_ready;
            fbits[mcnt] = dout;
            if (mcnt == 8'd0) begin
                cur_fs = frame_start;
                cur_ur = underrun;
                cur_junk = 1'b0;
            end else if (frame_start !== 1'b0 || underrun !== 1'b0) begin
                cur_junk = 1'b1;
            end
            if (mcnt == 8'hFF) begin
                f = '0;
                f.fs = cur_fs;
                f.ur = cur_ur;
                f.junk = cur_junk;
                for (int ch = 0; ch < 2; ch++) begin
                    for (int k = 0; k < 32; k++) begin
                        b = fbits[ch*128 + k*4];
                        if (k >= 1 && k <= W) begin
                            if (ch == 0) f.l[W-k] = b;
                            else         f.r[W-k] = b;
                        end else if (b !== 1'b0) begin
                            f.junk = 1'b1;
                        end
                    end
                end
                got_q.push_back(f);
                e = '0;
                e.fs = 1'b1;
                if (pend.size() > 0) begin
                    p = pend.pop_front();
                    e.l = p.l;
                    e.r = p.r;
                end else begin
                    e.ur = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (acc) pend.push_back({sif.s_left, sif.s_right});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [7:0] v, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (mcnt == v) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < (n + 2) * 256; i++) begin
            if (got_q.size() >= gi + n) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic send(input pair_t v, output bit ok, output int t);
        bit rdy;
        ok = 0;
        t = 0;
        sif.s_left = v.l;
        sif.s_right = v.r;
        sif.s_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rdy = sif.s_ready;
            tick();
            if (rdy) begin
                ok = 1;
                t = cyc;
                break;
            end
        end
        sif.s_valid = 1'b0;
    endtask

    function automatic pair_t rnd_pair();
        return {24'($urandom), 24'($urandom)};
    endfunction

    task automatic test_reset();
        bit ok;
        frm_t g;
        repeat (3) tick();
        total++;
        if ({bck, lrck, dout, frame_start, underrun, sif.s_ready} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_outs got=%b want=000001",
                {bck, lrck, dout, frame_start, underrun, sif.s_ready});
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        gi = 0;
        total++;
        if (sif.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", sif.s_ready);
        end
        wait_frames(1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_frame0 got=timeout want=frame");
        end else begin
            g = got_q[gi];
            if (g !== frm_t'('0) || g !== exp_q[gi]) begin
                bad++;
                $display("FAIL reset_frame0 got=%h want=0", g);
            end
            gi++;
        end
    endtask

    task automatic test_single();
        bit ok;
        int t;
        pair_t v;
        frm_t g;
        wait_cnt(8'd10, ok);
        gi = got_q.size();
        v = {24'hA5A5A5, 24'h3C0F81};
        send(v, ok, t);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_accept got=timeout want=accept");
        end
        wait_frames(2, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_frames got=timeout want=2 frames");
            return;
        end
        for (int i = 0; i < 2; i++) begin
            g = got_q[gi + i];
            total++;
            if (g !== exp_q[gi + i]) begin
                bad++;
                $display("FAIL single_frame%0d got=%h want=%h",
                    i, g, exp_q[gi + i]);
            end
        end
        g = got_q[gi + 1];
        total++;
        if ({g.l, g.r, g.fs, g.ur, g.junk} !== {24'hA5A5A5, 24'h3C0F81, 3'b100}) begin
            bad++;
            $display("FAIL single_data got=%h/%h fs=%b ur=%b junk=%b want=a5a5a5/3c0f81 100",
                g.l, g.r, g.fs, g.ur, g.junk);
        end
        gi += 2;
    endtask

    task automatic test_geometry();
        int g0, b0, l0;
        g0 = geo_err;
        b0 = bck_rise;
        l0 = lrck_rise;
        repeat (1024) tick();
        total++;
        if (geo_err - g0 !== 0) begin
            bad++;
            $display("FAIL geo_timing got=%0d errors want=0", geo_err - g0);
        end
        total++;
        if (bck_rise - b0 !== 256) begin
            bad++;
            $display("FAIL geo_bck_rises got=%0d want=256", bck_rise - b0);
        end
        total++;
        if (lrck_rise - l0 !== 4) begin
            bad++;
            $display("FAIL geo_lrck_rises got=%0d want=4", lrck_rise - l0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t[6];
        int r0;
        logic [W-1:0] base;
        pair_t v;
        frm_t g;
        wait_cnt(8'd10, ok);
        gi = got_q.size();
        r0 = rdy_err;
        base = 24'($urandom_range(0, 24'h7FFFFF));
        for (int i = 0; i < 6; i++) begin
            v.l = base + W'(i + 1);
            v.r = 24'($urandom);
            send(v, ok, t[i]);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_accept%0d got=timeout want=accept", i);
            end
        end
        for (int i = 2; i < 6; i++) begin
            total++;
            if (t[i] - t[i-1] !== 256) begin
                bad++;
                $display("FAIL b2b_spacing%0d got=%0d want=256", i, t[i] - t[i-1]);
            end
        end
        wait_frames(7, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_frames got=timeout want=7 frames");
            return;
        end
        for (int i = 0; i < 7; i++) begin
            g = got_q[gi + i];
            total++;
            if (g !== exp_q[gi + i]) begin
                bad++;
                $display("FAIL b2b_frame%0d got=%h want=%h", i, g, exp_q[gi + i]);
            end
            if (i > 0) begin
                total++;
                if (g.l !== base + W'(i) || g.fs !== 1'b1 || g.ur !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_seq%0d got=%h want=%h", i, g.l, base + W'(i));
                end
            end
        end
        total++;
        if (rdy_err - r0 !== 0) begin
            bad++;
            $display("FAIL b2b_ready got=%0d errors want=0", rdy_err - r0);
        end
        gi += 7;
    endtask

    task automatic test_simultaneous();
        bit ok;
        int t;
        pair_t x, y;
        frm_t g;
        wait_cnt(8'd10, ok);
        gi = got_q.size();
        x = rnd_pair();
        y = rnd_pair();
        send(x, ok, t);
        send(y, ok, t);
        total++;
        if (!ok || mcnt !== 8'd0) begin
            bad++;
            $display("FAIL simul_accept_at_load got=cnt %0d want=cnt 0", mcnt);
        end
        total++;
        if (sif.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL simul_hold_full got=%b want=0", sif.s_ready);
        end
        wait_frames(3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL simul_frames got=timeout want=3 frames");
            return;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q[gi + i] !== exp_q[gi + i]) begin
                bad++;
                $display("FAIL simul_frame%0d got=%h want=%h",
                    i, got_q[gi + i], exp_q[gi + i]);
            end
        end
        g = got_q[gi + 1];
        total++;
        if ({g.l, g.r} !== x) begin
            bad++;
            $display("FAIL simul_x got=%h want=%h", {g.l, g.r}, x);
        end
        g = got_q[gi + 2];
        total++;
        if ({g.l, g.r} !== y) begin
            bad++;
            $display("FAIL simul_y got=%h want=%h", {g.l, g.r}, y);
        end
        gi += 3;
    endtask

    task automatic test_underrun();
        bit ok;
        int t;
        frm_t w;
        wait_cnt(8'd10, ok);
        gi = got_q.size();
        send(rnd_pair(), ok, t);
        wait_frames(4, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL underrun_frames got=timeout want=4 frames");
            return;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_q[gi + i] !== exp_q[gi + i]) begin
                bad++;
                $display("FAIL underrun_frame%0d got=%h want=%h",
                    i, got_q[gi + i], exp_q[gi + i]);
            end
        end
        w = '0;
        w.fs = 1'b1;
        w.ur = 1'b1;
        for (int i = 2; i < 4; i++) begin
            total++;
            if (got_q[gi + i] !== w) begin
                bad++;
                $display("FAIL underrun_mute%0d got=%h want=%h", i, got_q[gi + i], w);
            end
        end
        gi += 4;
    endtask

    task automatic test_mid_reset();
        bit ok;
        int t;
        logic [7:0] rc [2];
        rc[0] = 8'd100;
        rc[1] = 8'd202;
        for (int n = 0; n < 2; n++) begin
            wait_cnt(8'd10, ok);
            send({24'($urandom) | 24'h800001, 24'($urandom) | 24'h800001}, ok, t);
            wait_cnt(8'hFF, ok);
            tick();
            wait_cnt(rc[n], ok);
            reset = 1'b1;
            #1;
            total++;
            if ({bck, lrck, dout, frame_start, underrun, sif.s_ready} !== 6'b000001) begin
                bad++;
                $display("FAIL midrst%0d_outs got=%b want=000001", rc[n],
                    {bck, lrck, dout, frame_start, underrun, sif.s_ready});
            end
            repeat (3) tick();
            @(posedge clk);
            #2;
            reset = 1'b0;
            gi = 0;
            total++;
            if (sif.s_ready !== 1'b1 || mcnt !== 8'd0) begin
                bad++;
                $display("FAIL midrst%0d_release got=ready %b want=1", rc[n], sif.s_ready);
            end
            wait_frames(2, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL midrst%0d_frames got=timeout want=2 frames", rc[n]);
            end else begin
                if (got_q[0] !== frm_t'('0) || got_q[1] !== exp_q[1]) begin
                    bad++;
                    $display("FAIL midrst%0d_frame0 got=%h/%h want=%h/%h", rc[n],
                        got_q[0], got_q[1], frm_t'('0), exp_q[1]);
                end
                gi = 2;
            end
        end
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_left = '0;
        sif.s_right = '0;
        test_reset();
        test_single();
        test_geometry();
        test_back_to_back();
        test_simultaneous();
        test_underrun();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
I2S transmitter, the playback-direction counterpart of the PCM1808 capture path. It accepts 24-bit left/right sample pairs from the DSP datapath over a valid/ready handshake and double-buffers them. It generates SCKI/BCK/LRCK from the single system clock and serializes standard I2S data (MSB one BCK after the LRCK edge) to an external DAC (PCM5102-class).
- Frame timing: 256 clk per frame, Fs = clk/256 (46.875 kHz at 12 MHz), 32 BCK slots per channel.

Parameters:
DATA_W, 24, sample width in bits; legal range 1..31 (must fit in 32 slots after the 1-slot delay).

Ports:
clk  input  1  system clock, 12 MHz; also forwarded as SCKI.
reset  input  1  asynchronous, active-high reset.
s_left  input  DATA_W  left sample, two's complement.
s_right  input  DATA_W  right sample, two's complement.
s_valid  input  1  sample pair valid.
s_ready  output  1  holding buffer can accept a pair.
scki  output  1  DAC system clock; equals clk (256*Fs).
bck  output  1  bit clock, clk/4.
lrck  output  1  word select, clk/256; 0 = left, 1 = right.
dout  output  1  serial data to DAC.
frame_start  output  1  one-clk pulse when a new pair is loaded into the shifters.
underrun  output  1  one-clk pulse when a frame starts with the holding buffer empty.

Behaviour:
- Frame counter:
  - cnt[7:0] increments every clk and wraps 255->0.
  - Slot = cnt[6:2]. Channel = cnt[7].
- Output registers:
  - bck, lrck and dout are registers, each updated from next-cnt, so in any cycle they are the following functions of the current cnt:
  - bck = cnt[1]. BCK falls at cnt[1:0]==0 and rises at cnt[1:0]==2, so the DAC samples mid-bit.
  - lrck = cnt[7].
  - dout: for slot k in 1..DATA_W, dout = bit (DATA_W-k) of the current channel's word (MSB first). For slot 0 and slots DATA_W+1..31, dout = 0.
  - dout changes only when cnt[1:0]==0.
- Shifters:
  - tx_l/tx_r hold the pair being sent. They are loaded only on the clk edge where cnt==255, taking effect at cnt==0.
  - Both channels of a frame always come from the same accepted pair.
- Holding buffer (depth 1):
  - hold_l, hold_r, hold_valid.
  - s_ready = !hold_valid || (cnt==255). This is combinational.
  - Accept when s_valid && s_ready.
- Frame load (cnt==255 edge):
  - If hold_valid: tx <= hold, and frame_start pulses in the cycle where cnt==0.
  - If not hold_valid: tx <= 0 (mute frame), and underrun pulses in the cycle where cnt==0; frame_start also pulses.
- Hold bookkeeping at the load edge:
  - hold_valid <= 1 if an accept occurs in that same cycle, with the new pair written to hold; otherwise hold_valid <= 0.
  - Outside the load edge, an accept sets hold_valid.
  - No pair is ever dropped or sent twice.
- Back-pressure and throughput:
  - With hold full, s_ready stays low until the next cnt==255.
  - Maximum throughput is one pair per frame.
- Reset (asynchronous, mid-operation allowed):
  - cnt=0, bck=0, lrck=0, dout=0.
  - tx_l=tx_r=0, hold_valid=0, frame_start=0, underrun=0.
  - s_ready=1 from reset assertion.
- After reset release:
  - Frame 0 transmits zeros and flags neither underrun nor frame_start.
  - The first load decision is at the first cnt==255.
- scki is clk passed through. This is the only non-registered clock output.

Decomposition:
- Package i2s_pkg:
  - SAMPLE_W=24, SLOTS_PER_CH=32, CLK_PER_BCK=4, CLK_PER_FRAME=256.
  - typedef logic [SAMPLE_W-1:0] sample_t.
  - typedef logic [4:0] slot_t.
  - Function bit_index(slot) returning the bit position or none.
- Sub-module i2s_clkgen:
  - Owns cnt and the registered bck/lrck.
  - Exports slot, channel and a load strobe (cnt==255).
  - Reusable later by the receiver so both directions share one frame phase.

Test Plan:
- Single pair: reset, then s_left=24'hA5A5A5, s_right=24'h3C0F81 with s_valid held until accepted.
  - The next frame's dout in left slots 1..24 = A5A5A5 MSB-first.
  - Right slots 1..24 = 3C0F81.
  - All other slots = 0.
  - frame_start pulses once; underrun stays 0.
- Clock geometry: over 1024 clk after reset, check:
  - bck period 4 with rising edges at cnt[1:0]==2.
  - lrck period 256, 50% duty.
  - dout transitions only at bck falling edges.
- Back-pressure: drive s_valid continuously with incrementing values 1,2,3…
  - Exactly one pair is accepted per 256 clk.
  - s_ready is low between accept and cnt==255.
  - Frames carry 1,2,3… in order with no gaps or repeats.
- Simultaneous load and accept: present a pair exactly at cnt==255 while hold is full (value X, new value Y).
  - The frame sends X.
  - The next frame sends Y.
  - hold_valid stays 1 across the edge.
- Underrun: stop s_valid after one pair.
  - The following frame is all-zero dout.
  - underrun pulses for 1 clk at cnt==0 and pulses again each empty frame.
- Mid-frame reset: assert reset at cnt==100 during a non-zero frame.
  - All outputs go 0 immediately.
  - After release: cnt restarts at 0, frame 0 is zeros, no underrun, s_ready=1.
